logic_unit_seq: RTL

Sequential front-end for the 32-bit logical unit: accepts an operand pair and opcode over a valid/ready handshake, evaluates the selected bitwise function one slice per cycle (LSB slice first), and presents a registered result with zero/negative flags over a second valid/ready handshake. It sits between the ALU operand/decode stage and the ALU result mux, and it wraps the combinational per-bit NOT/AND/OR/XOR cells as the slice datapath.

---
 rtl/logic_unit_seq.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/logic_unit_seq.sv
// logic_unit_seq: sequential front-end for the 32-bit logical unit.
// Accepts an operand pair and opcode over a valid/ready handshake. Evaluates
// the selected bitwise function one SLICE-bit slice per cycle, LSB slice
// first. Presents a registered result with zero/negative flags over a second
// valid/ready handshake.
// WIDTH must be a multiple of SLICE.
module logic_unit_seq #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             neg
);

    localparam int N     = WIDTH / SLICE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [2:0]              op_q, op_d;
    logic [WIDTH-1:0]        a_q, a_d;
    logic [WIDTH-1:0]        b_q, b_d;
    logic [WIDTH-1:0]        res_q, res_d;
    logic                    zero_q, zero_d;
    logic                    neg_q, neg_d;
    logic [SLICE-1:0]        slice_res;
    logic [WIDTH-1:0]        res_full;

    // Per-slice bitwise cell. There are no carries, so every slice is
    // independent of its neighbours.
    function automatic logic [SLICE-1:0] slice_fn(
        input logic [2:0]       f,
        input logic [SLICE-1:0] x,
        input logic [SLICE-1:0] y
    );
        logic [SLICE-1:0] r;
        case (f)
            3'b000:  r = x & y;
            3'b001:  r = x | y;
            3'b010:  r = x ^ y;
            3'b011:  r = ~x;
            3'b100:  r = ~(x & y);
            3'b101:  r = ~(x | y);
            3'b110:  r = ~(x ^ y);
            default: r = x;
        endcase
        return r;
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode: accept in IDLE, walk N slices in BUSY, hold in DONE until consumed.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)          state_d = BUSY;
            BUSY:    if (cnt_q == CNT_LAST) state_d = DONE;
            DONE:    if (out_ready)         state_d = IDLE;
            default:                        state_d = IDLE;
        endcase
    end

    // Datapath next values: capture on accept, merge one slice per BUSY cycle, flags on the last slice.
    always_comb begin
        cnt_d     = cnt_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        zero_d    = zero_q;
        neg_d     = neg_q;
        slice_res = slice_fn(op_q, a_q[cnt_q*SLICE +: SLICE], b_q[cnt_q*SLICE +: SLICE]);
        res_full  = res_q;
        res_full[cnt_q*SLICE +: SLICE] = slice_res;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d   = a;
                    b_d   = b;
                    op_d  = op;
                    res_d = '0;
                    cnt_d = '0;
                end
            end
            BUSY: begin
                res_d = res_full;
                if (cnt_q == CNT_LAST) begin
                    zero_d = (res_full == '0);
                    neg_d  = res_full[WIDTH-1];
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Datapath registers. Reset clears them so that an aborted operation
    // leaves nothing behind.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            res_q  <= '0;
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            op_q   <= op_d;
            a_q    <= a_d;
            b_q    <= b_d;
            res_q  <= res_d;
            zero_q <= zero_d;
            neg_q  <= neg_d;
        end
    end

    // Handshakes are decoded from the state register, forced low while in
    // reset. Result and flags are gated so that partial slices never show.
    assign in_ready  = rst_n && (state_q == IDLE);
    assign out_valid = rst_n && (state_q == DONE);
    assign result    = out_valid ? res_q : '0;
    assign zero      = out_valid & zero_q;
    assign neg       = out_valid & neg_q;

endmodule
